sa_output_fifo_mc: RTL and testbench

//  Multi-channel output buffer for the systolic-array (SA) result path: one circular FIFO lane per SA column.

---
 rtl/sa_output_fifo_mc.sv | 160 ++++++++++++++++
 tb/tb_sa_output_fifo_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sa_output_fifo_mc.sv
// Multi-channel output FIFO for the systolic-array result path.
// One circular FIFO lane per SA column, drained either a full row at a time
// (parallel) or one word at a time in strict column order (serial).

// Single circular FIFO lane: storage, pointers, occupancy and status flags.
module sa_output_fifo_lane #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AF    = DEPTH - 2
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic          I_CLR,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok, pop_ok;

    // Flags follow the registered count directly, so they never disagree with it.
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AF));
    assign head        = mem[rd_ptr];

    // A full lane still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop) & ~I_CLR;
    assign pop_ok  = pop & ~empty & ~I_CLR;
    assign drop    = push & full & ~pop & ~I_CLR;

    // Pointer/count/storage update; flush leaves storage contents untouched.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (I_CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Top: lane array plus drain-mode control and the shared pop port.
module sa_output_fifo_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_CH     = 4,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2
) (
    input  logic                         I_CLK,
    input  logic                         I_RST,
    input  logic                         I_CLR,
    input  logic                         I_MODE,
    input  logic [NUM_CH-1:0]            I_PUSH_EN,
    input  logic [NUM_CH*DATA_WIDTH-1:0] I_PUSH_DATA,
    output logic                         O_POP_VALID,
    input  logic                         I_POP_READY,
    output logic [NUM_CH*DATA_WIDTH-1:0] O_POP_DATA,
    output logic [$clog2(NUM_CH)-1:0]    O_POP_CH,
    output logic [NUM_CH-1:0]            O_FULL,
    output logic [NUM_CH-1:0]            O_EMPTY,
    output logic                         O_ALMOST_FULL,
    output logic                         O_OVERFLOW
);
    localparam int CHW = $clog2(NUM_CH);

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] push_word, head, pop_word;
    logic [NUM_CH-1:0]                 lane_pop, lane_af, lane_drop;
    logic                              mode_q, xfer, all_empty;
    logic [CHW-1:0]                    rr_q;
    logic                              ovf_q;

    assign push_word = I_PUSH_DATA;
    assign all_empty = &O_EMPTY;

    assign O_POP_VALID   = mode_q ? ~O_EMPTY[rr_q] : &(~O_EMPTY);
    assign xfer          = O_POP_VALID & I_POP_READY;
    assign O_POP_CH      = mode_q ? rr_q : '0;
    assign O_ALMOST_FULL = |lane_af;
    assign O_OVERFLOW    = ovf_q;
    assign O_POP_DATA    = pop_word;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        // Parallel drains every lane together; serial drains only the rr lane.
        assign lane_pop[c] = xfer & (~mode_q | (rr_q == CHW'(c)));

        sa_output_fifo_lane #(
            .DW    (DATA_WIDTH),
            .DEPTH (FIFO_DEPTH),
            .AF    (AF_LEVEL)
        ) u_lane (
            .I_CLK       (I_CLK),
            .I_RST       (I_RST),
            .I_CLR       (I_CLR),
            .push        (I_PUSH_EN[c]),
            .pop         (lane_pop[c]),
            .wdata       (push_word[c]),
            .head        (head[c]),
            .full        (O_FULL[c]),
            .empty       (O_EMPTY[c]),
            .almost_full (lane_af[c]),
            .drop        (lane_drop[c])
        );
    end

    // Steer head words onto the output: whole row, or the selected head in slice 0.
    always_comb begin
        pop_word = '0;
        if (mode_q) pop_word[0] = head[rr_q];
        else        pop_word    = head;
    end

    // Mode only changes while nothing is buffered; rr walks columns in strict order.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            mode_q <= 1'b0;
            rr_q   <= '0;
        end else begin
            if (all_empty) mode_q <= I_MODE;
            if (I_CLR)
                rr_q <= '0;
            else if (all_empty & I_MODE & ~mode_q)
                rr_q <= '0;
            else if (mode_q & xfer)
                rr_q <= (rr_q == CHW'(NUM_CH - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    // Sticky overflow: set by any dropped push, cleared only by flush or reset.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST)          ovf_q <= 1'b0;
        else if (I_CLR)     ovf_q <= 1'b0;
        else if (|lane_drop) ovf_q <= 1'b1;
    end
endmodule

// File: tb/tb_sa_output_fifo_mc.sv
// Directed bench for sa_output_fifo_mc (NUM_CH=4, DEPTH=16, DW=8).
module tb_sa_output_fifo_mc;
    logic        clk, rst, clr, mode, ready;
    logic [3:0]  push_en;
    logic [31:0] push_data;
    logic        valid, af, ovf;
    logic [31:0] pop_data;
    logic [1:0]  pop_ch;
    logic [3:0]  full, empty;

    int passed = 0;
    int total  = 0;

    sa_output_fifo_mc #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .NUM_CH     (4),
        .AF_LEVEL   (14)
    ) dut (
        .I_CLK         (clk),
        .I_RST         (rst),
        .I_CLR         (clr),
        .I_MODE        (mode),
        .I_PUSH_EN     (push_en),
        .I_PUSH_DATA   (push_data),
        .O_POP_VALID   (valid),
        .I_POP_READY   (ready),
        .O_POP_DATA    (pop_data),
        .O_POP_CH      (pop_ch),
        .O_FULL        (full),
        .O_EMPTY       (empty),
        .O_ALMOST_FULL (af),
        .O_OVERFLOW    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 0; mode = 0; ready = 0; push_en = 0; push_data = 0;
        #3;
        total++; if (valid !== 1'b0)      $display("FAIL rst_valid got %0b exp 0", valid); else passed++;
        total++; if (pop_data !== 32'h0)  $display("FAIL rst_data got %h exp 0", pop_data); else passed++;
        total++; if (pop_ch !== 2'd0)     $display("FAIL rst_ch got %0d exp 0", pop_ch); else passed++;
        total++; if (full !== 4'h0)       $display("FAIL rst_full got %h exp 0", full); else passed++;
        total++; if (empty !== 4'hF)      $display("FAIL rst_empty got %h exp F", empty); else passed++;
        total++; if (af !== 1'b0)         $display("FAIL rst_af got %0b exp 0", af); else passed++;
        total++; if (ovf !== 1'b0)        $display("FAIL rst_ovf got %0b exp 0", ovf); else passed++;
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_parallel();
        logic [31:0] row;
        mode = 0;
        for (int r = 0; r < 16; r++) begin
            push_en   = 4'hF;
            push_data = {8'(r*4+3), 8'(r*4+2), 8'(r*4+1), 8'(r*4)};
            tick();
            if (r == 0) begin
                total++; if (valid !== 1'b1) $display("FAIL par_first_valid got %0b exp 1", valid); else passed++;
            end
            if (r == 12) begin
                total++; if (af !== 1'b0) $display("FAIL par_af_13 got %0b exp 0", af); else passed++;
            end
            if (r == 13) begin
                total++; if (af !== 1'b1) $display("FAIL par_af_14 got %0b exp 1", af); else passed++;
            end
        end
        push_en = 0;
        total++; if (full !== 4'hF)  $display("FAIL par_full got %h exp F", full); else passed++;
        total++; if (empty !== 4'h0) $display("FAIL par_notempty got %h exp 0", empty); else passed++;
        ready = 1;
        for (int r = 0; r < 16; r++) begin
            row = {8'(r*4+3), 8'(r*4+2), 8'(r*4+1), 8'(r*4)};
            total++;
            if (valid !== 1'b1 || pop_data !== row)
                $display("FAIL par_row%0d got v=%0b d=%h exp v=1 d=%h", r, valid, pop_data, row);
            else passed++;
            tick();
        end
        ready = 0;
        total++; if (empty !== 4'hF) $display("FAIL par_drained got %h exp F", empty); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL par_valid_end got %0b exp 0", valid); else passed++;
    endtask

    task automatic test_skew();
        mode = 0;
        push_data = 32'h33323130;
        for (int c = 0; c < 4; c++) begin
            push_en = 4'(1 << c);
            tick();
            if (c < 3) begin
                total++; if (valid !== 1'b0) $display("FAIL skew_early%0d got %0b exp 0", c, valid); else passed++;
            end
        end
        push_en = 0;
        total++; if (valid !== 1'b1) $display("FAIL skew_valid got %0b exp 1", valid); else passed++;
        total++; if (pop_data !== 32'h33323130) $display("FAIL skew_data got %h exp 33323130", pop_data); else passed++;
        ready = 1; tick(); ready = 0;
        total++; if (empty !== 4'hF) $display("FAIL skew_drain got %h exp F", empty); else passed++;
    endtask

    task automatic test_serial();
        logic [31:0] exp_d;
        mode = 1; tick();
        push_en = 4'hF; push_data = 32'h13121110; tick(); push_en = 0;
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'h10 + 32'(i);
            total++;
            if (valid !== 1'b1 || pop_ch !== 2'(i) || pop_data !== exp_d)
                $display("FAIL ser_xfer%0d got v=%0b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                         i, valid, pop_ch, pop_data, i, exp_d);
            else passed++;
            tick();
        end
        ready = 0;
        total++; if (valid !== 1'b0) $display("FAIL ser_valid_end got %0b exp 0", valid); else passed++;
        total++; if (pop_ch !== 2'd0) $display("FAIL ser_rr_wrap got %0d exp 0", pop_ch); else passed++;
    endtask

    task automatic test_overflow();
        // serial mode, rr=0
        push_en = 4'h1;
        for (int k = 0; k < 16; k++) begin
            push_data = {24'h0, 8'(8'h20 + k)};
            tick();
        end
        total++; if (full !== 4'h1) $display("FAIL ovf_full got %h exp 1", full); else passed++;
        total++; if (pop_data !== 32'h20) $display("FAIL ovf_head got %h exp 20", pop_data); else passed++;
        push_data = 32'h99; ready = 1; tick(); ready = 0;
        total++; if (full !== 4'h1 || ovf !== 1'b0)
            $display("FAIL ovf_pushpop got full=%h ovf=%0b exp full=1 ovf=0", full, ovf); else passed++;
        total++; if (pop_ch !== 2'd1 || valid !== 1'b0)
            $display("FAIL ovf_rr got ch=%0d v=%0b exp ch=1 v=0", pop_ch, valid); else passed++;
        tick();
        push_en = 0;
        total++; if (ovf !== 1'b1) $display("FAIL ovf_drop got %0b exp 1", ovf); else passed++;
        tick();
        total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got %0b exp 1", ovf); else passed++;
        clr = 1; tick(); clr = 0;
        total++; if (ovf !== 1'b0 || empty !== 4'hF || full !== 4'h0 || pop_ch !== 2'd0)
            $display("FAIL ovf_clr got ovf=%0b e=%h f=%h ch=%0d exp 0 F 0 0", ovf, empty, full, pop_ch);
        else passed++;
    endtask

    task automatic test_hold();
        // serial mode
        push_en = 4'h3; push_data = 32'h00006655; tick(); push_en = 0;
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            mode = ~mode;
            tick();
            total++;
            if (valid !== 1'b1 || pop_data !== 32'h55 || pop_ch !== 2'd0 || empty !== 4'hC)
                $display("FAIL hold%0d got v=%0b d=%h ch=%0d e=%h exp 1 55 0 C", i, valid, pop_data, pop_ch, empty);
            else passed++;
        end
        mode = 1; ready = 1; tick();
        total++; if (pop_data !== 32'h66 || pop_ch !== 2'd1)
            $display("FAIL hold_next got d=%h ch=%0d exp 66 1", pop_data, pop_ch); else passed++;
        tick(); ready = 0;
        total++; if (valid !== 1'b0 || empty !== 4'hF)
            $display("FAIL hold_drain got v=%0b e=%h exp 0 F", valid, empty); else passed++;
        mode = 0; tick();
        total++; if (pop_ch !== 2'd0) $display("FAIL hold_par_ch got %0d exp 0", pop_ch); else passed++;
    endtask

    task automatic test_reset_mid();
        mode = 0;
        for (int r = 0; r < 3; r++) begin
            push_en = 4'hF;
            push_data = {8'(8'hA3 + r*4), 8'(8'hA2 + r*4), 8'(8'hA1 + r*4), 8'(8'hA0 + r*4)};
            tick();
        end
        push_en = 0; ready = 1; tick(); ready = 0;
        total++; if (pop_data !== 32'hA7A6A5A4) $display("FAIL mid_row1 got %h exp A7A6A5A4", pop_data); else passed++;
        rst = 1; #1;
        total++;
        if (valid !== 1'b0 || pop_data !== 32'h0 || pop_ch !== 2'd0 || full !== 4'h0 ||
            empty !== 4'hF || af !== 1'b0 || ovf !== 1'b0)
            $display("FAIL mid_rst got v=%0b d=%h ch=%0d f=%h e=%h af=%0b ovf=%0b exp reset values",
                     valid, pop_data, pop_ch, full, empty, af, ovf);
        else passed++;
        #1 rst = 0;
        push_en = 4'hF; push_data = 32'h04030201; tick(); push_en = 0;
        total++; if (valid !== 1'b1 || pop_data !== 32'h04030201)
            $display("FAIL mid_resume got v=%0b d=%h exp 1 04030201", valid, pop_data); else passed++;
        ready = 1; tick(); ready = 0;
        total++; if (empty !== 4'hF || valid !== 1'b0)
            $display("FAIL mid_final got e=%h v=%0b exp F 0", empty, valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_parallel();
        test_skew();
        test_serial();
        test_overflow();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
